// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: parity codes, receiver
// FSM states and the bit-period helper.
package uart_pkg;

  localparam logic [1:0] C_PARITY_NONE = 2'd0;
  localparam logic [1:0] C_PARITY_EVEN = 2'd1;
  localparam logic [1:0] C_PARITY_ODD  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  function automatic int unsigned calc_bit_period(input int unsigned clock_freq,
                                                  input int unsigned baudrate);
    return clock_freq / baudrate;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head word is always presented on rd_data_o
// while rd_valid_o is high. A push into a full FIFO is kept only if a pop happens
// in the same cycle.
module sync_fifo_fwft #(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic [G_DATA_WIDTH-1:0] wr_data_i,
  input  logic                    rd_ready_i,
  output logic [G_DATA_WIDTH-1:0] rd_data_o,
  output logic                    rd_valid_o,
  output logic [G_ADDR_WIDTH:0]   count_o,
  output logic                    overflow_o
);

  localparam int C_DEPTH = 2 ** G_ADDR_WIDTH;
  localparam int C_CNT_W = G_ADDR_WIDTH + 1;

  logic [G_DATA_WIDTH-1:0] mem_q [C_DEPTH];
  logic [G_ADDR_WIDTH-1:0] wr_ptr_q;
  logic [G_ADDR_WIDTH-1:0] rd_ptr_q;
  logic [C_CNT_W-1:0]      count_q;
  logic [C_CNT_W-1:0]      count_d;
  logic                    full_s;
  logic                    pop_s;
  logic                    accept_s;

  assign full_s     = (count_q == C_CNT_W'(C_DEPTH));
  assign pop_s      = rd_ready_i & (count_q != '0);
  assign accept_s   = wr_en_i & (~full_s | pop_s);
  assign overflow_o = wr_en_i & full_s & ~pop_s;
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign rd_valid_o = (count_q != '0);
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < C_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (accept_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver: synchronizes the line, samples mid-bit, checks parity and stop
// bits, and queues good frames into a FWFT FIFO for a valid/ready consumer.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned G_CLOCK_FREQ        = 20000000,
  parameter int unsigned G_BAUDRATE          = 115200,
  parameter int unsigned G_DATA_WIDTH        = 8,
  parameter int unsigned G_PARITY            = 0,
  parameter int unsigned G_STOP_BIT_NUMBER   = 1,
  parameter int unsigned G_FIRST_BIT         = 0,
  parameter int unsigned G_BUFFER_ADDR_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rx,
  output logic [G_DATA_WIDTH-1:0]      o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [G_BUFFER_ADDR_WIDTH:0] o_fifo_count,
  output logic                         o_busy,
  output logic                         o_parity_err,
  output logic                         o_frame_err,
  output logic                         o_overflow
);

  localparam int unsigned C_BIT_PERIOD = calc_bit_period(G_CLOCK_FREQ, G_BAUDRATE);
  localparam int unsigned C_TICK_W     = $clog2(C_BIT_PERIOD);
  localparam logic [C_TICK_W-1:0] C_TICK_FULL = C_TICK_W'(C_BIT_PERIOD - 1);
  localparam logic [C_TICK_W-1:0] C_TICK_HALF = C_TICK_W'(C_BIT_PERIOD / 2);
  localparam logic [3:0] C_LAST_BIT  = 4'(G_DATA_WIDTH - 1);
  localparam logic       C_LAST_STOP = 1'(G_STOP_BIT_NUMBER - 1);
  localparam logic [1:0] C_PAR       = 2'(G_PARITY);
  localparam logic       C_HAS_PAR   = (C_PAR != C_PARITY_NONE);
  localparam logic       C_PAR_ODD   = (C_PAR == C_PARITY_ODD);
  localparam logic       C_MSB_FIRST = (G_FIRST_BIT != 0);

  rx_state_e               state_q, state_d;
  logic [1:0]              sync_q;
  logic                    rx_s;
  logic                    rx_prev_q;
  logic [C_TICK_W-1:0]     tick_q, tick_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic [G_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                    par_bad_q, par_bad_d;
  logic                    stop_bad_q, stop_bad_d;
  logic                    wr_q, wr_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    ovf_q;
  logic                    sample_s;
  logic                    fifo_ovf_s;

  assign rx_s     = sync_q[1];
  assign sample_s = (tick_q == '0);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    stop_bad_d = stop_bad_q;
    wr_d       = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    // Idle keeps the half-period preloaded so START samples mid start bit.
    if (state_q == S_IDLE) begin
      tick_d = C_TICK_HALF;
    end else if (sample_s) begin
      tick_d = C_TICK_FULL;
    end else begin
      tick_d = tick_q - 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        par_bad_d  = 1'b0;
        stop_bad_d = 1'b0;
        if (rx_prev_q & ~rx_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (sample_s) begin
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (sample_s) begin
          if (C_MSB_FIRST) begin
            shift_d = {shift_q[G_DATA_WIDTH-2:0], rx_s};
          end else begin
            shift_d = {rx_s, shift_q[G_DATA_WIDTH-1:1]};
          end
          if (bit_cnt_q == C_LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = C_HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (sample_s) begin
          par_bad_d = (^shift_q) ^ rx_s ^ C_PAR_ODD;
          state_d   = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (sample_s) begin
          if (stop_cnt_q == C_LAST_STOP) begin
            state_d = S_IDLE;
            if (stop_bad_q | ~rx_s) begin
              ferr_d = 1'b1;
            end else if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              wr_d = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
            stop_bad_d = stop_bad_q | ~rx_s;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      wr_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], i_rx};
      rx_prev_q  <= rx_s;
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      stop_bad_q <= stop_bad_d;
      wr_q       <= wr_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovf_q      <= fifo_ovf_s;
    end
  end

  sync_fifo_fwft #(
    .G_DATA_WIDTH (int'(G_DATA_WIDTH)),
    .G_ADDR_WIDTH (int'(G_BUFFER_ADDR_WIDTH))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_q),
    .wr_data_i  (shift_q),
    .rd_ready_i (i_ready),
    .rd_data_o  (o_data),
    .rd_valid_o (o_valid),
    .count_o    (o_fifo_count),
    .overflow_o (fifo_ovf_s)
  );

  assign o_busy       = (state_q != S_IDLE);
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: an 8N1 instance (0) and an 8E1 instance (1) driven
// by a bit-level line model, checked against a frame-level reference queue.
module tb_uart_rx_buffered;

  localparam int BP = 20000000 / 115200;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx     [2];
  logic       ready  [2];
  logic [7:0] data   [2];
  logic       valid  [2];
  logic [3:0] count  [2];
  logic       busy   [2];
  logic       perr   [2];
  logic       ferr   [2];
  logic       ovf    [2];

  // reference model: expected words per instance plus expected pulse totals
  logic [7:0] exp_mem [2][256];
  int         wr_idx [2] = '{0, 0};
  int         rd_idx [2] = '{0, 0};
  int         exp_perr [2] = '{0, 0};
  int         exp_ferr [2] = '{0, 0};
  int         exp_ovf  [2] = '{0, 0};

  int         seen_perr [2] = '{0, 0};
  int         seen_ferr [2] = '{0, 0};
  int         seen_ovf  [2] = '{0, 0};
  logic       hold_q    [2] = '{1'b0, 1'b0};
  logic [7:0] hold_data [2];
  logic       prev_pulse [2] = '{1'b0, 1'b0};

  int          checks = 0;
  int          errors = 0;
  int          req_seq = 0;
  int          ack_seq = 0;
  int          req_k;
  int          req_sel;
  logic [31:0] req_exp;
  logic [31:0] req_aux;
  string       req_name;

  always #5 clk = ~clk;

  uart_rx_buffered #(.G_PARITY(0)) dut0 (
    .clk(clk), .rst(rst), .i_rx(rx[0]), .o_data(data[0]), .o_valid(valid[0]),
    .i_ready(ready[0]), .o_fifo_count(count[0]), .o_busy(busy[0]),
    .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_overflow(ovf[0])
  );

  uart_rx_buffered #(.G_PARITY(1)) dut1 (
    .clk(clk), .rst(rst), .i_rx(rx[1]), .o_data(data[1]), .o_valid(valid[1]),
    .i_ready(ready[1]), .o_fifo_count(count[1]), .o_busy(busy[1]),
    .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_overflow(ovf[1])
  );

  // Compare process: per-cycle protocol checks, pop ordering and checkpoint requests.
  initial begin
    logic [31:0] act;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          rd_idx[k]     = wr_idx[k];
          hold_q[k]     = 1'b0;
          prev_pulse[k] = 1'b0;
        end else begin
          checks++;
          if (valid[k] !== (count[k] != 4'd0)) begin
            errors++;
            $display("FAIL valid_vs_count dut%0d valid=%0b count=%0d", k, valid[k], count[k]);
          end
          if (hold_q[k]) begin
            checks++;
            if (data[k] !== hold_data[k]) begin
              errors++;
              $display("FAIL head_stable dut%0d act=%0h exp=%0h", k, data[k], hold_data[k]);
            end
          end
          if (valid[k] && ready[k]) begin
            checks++;
            if (rd_idx[k] >= wr_idx[k]) begin
              errors++;
              $display("FAIL unexpected_pop dut%0d act=%0h exp=none", k, data[k]);
            end else begin
              if (data[k] !== exp_mem[k][rd_idx[k]]) begin
                errors++;
                $display("FAIL pop_data dut%0d act=%0h exp=%0h", k, data[k], exp_mem[k][rd_idx[k]]);
              end
              rd_idx[k]++;
            end
          end
          hold_q[k]    = valid[k] && !ready[k];
          hold_data[k] = data[k];
          if (perr[k]) seen_perr[k]++;
          if (ferr[k]) seen_ferr[k]++;
          if (ovf[k])  seen_ovf[k]++;
          if (perr[k] || ferr[k] || ovf[k]) begin
            checks++;
            if ((perr[k] && ferr[k]) || prev_pulse[k]) begin
              errors++;
              $display("FAIL pulse_shape dut%0d perr=%0b ferr=%0b prev=%0b exp=single", k, perr[k], ferr[k], prev_pulse[k]);
            end
          end
          prev_pulse[k] = perr[k] || ferr[k] || ovf[k];
        end
      end
      if (req_seq != ack_seq) begin
        case (req_sel)
          0: act = 32'(data[req_k]);
          1: act = 32'(valid[req_k]);
          2: act = 32'(count[req_k]);
          3: act = 32'(busy[req_k]);
          4: act = 32'(seen_perr[req_k]);
          5: act = 32'(seen_ferr[req_k]);
          6: act = 32'(seen_ovf[req_k]);
          7: act = 32'(wr_idx[req_k] - rd_idx[req_k]);
          8: act = 32'(rd_idx[req_k]);
          9: act = req_aux;
          default: act = 32'hDEAD_BEEF;
        endcase
        checks++;
        if (act !== req_exp) begin
          errors++;
          $display("FAIL %s dut%0d act=%0h exp=%0h", req_name, req_k, act, req_exp);
        end
        ack_seq = req_seq;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_v(input int k, input int sel, input logic [31:0] exp, input string name);
    req_k    = k;
    req_sel  = sel;
    req_exp  = exp;
    req_name = name;
    req_seq++;
    cyc(1);
  endtask

  task automatic drive(input int k, input logic b);
    rx[k] = b;
    cyc(BP);
  endtask

  // Sends one LSB-first frame and records the outcome the receiver must produce.
  task automatic send_frame(input int k, input logic [7:0] d, input logic par_en,
                            input logic par_bit, input logic stop_bit, input logic pop_at_write);
    logic good;
    drive(k, 1'b0);
    for (int i = 0; i < 8; i++) drive(k, d[i]);
    if (par_en) drive(k, par_bit);
    good = !par_en || ((^d ^ par_bit) == 1'b0);
    if (!stop_bit) begin
      exp_ferr[k]++;
    end else if (!good) begin
      exp_perr[k]++;
    end else if ((wr_idx[k] - rd_idx[k]) >= 8 && !pop_at_write) begin
      exp_ovf[k]++;
    end else begin
      exp_mem[k][wr_idx[k]] = d;
      wr_idx[k]++;
    end
    drive(k, stop_bit);
    rx[k] = 1'b1;
    cyc(12);
  endtask

  task automatic check_pulses(input int k);
    expect_v(k, 4, 32'(exp_perr[k]), "perr_pulses");
    expect_v(k, 5, 32'(exp_ferr[k]), "ferr_pulses");
    expect_v(k, 6, 32'(exp_ovf[k]),  "ovf_pulses");
  endtask

  task automatic drain(input int k);
    ready[k] = 1'b1;
    cyc(12);
    ready[k] = 1'b0;
    cyc(2);
    expect_v(k, 2, 32'd0, "count_after_drain");
    expect_v(k, 7, 32'd0, "model_left_after_drain");
  endtask

  initial begin
    logic [7:0] burst [4];
    logic       saw;
    logic       done;
    int         n;
    burst = '{8'h55, 8'hA3, 8'h00, 8'hFF};
    rst = 1'b1;
    rx[0] = 1'b1; rx[1] = 1'b1;
    ready[0] = 1'b0; ready[1] = 1'b0;
    cyc(4);
    rst = 1'b0;
    cyc(1);

    // reset state
    expect_v(0, 0, 32'h00, "rst_data");
    expect_v(0, 1, 32'd0, "rst_valid");
    expect_v(0, 2, 32'd0, "rst_count");
    expect_v(0, 3, 32'd0, "rst_busy");
    expect_v(1, 2, 32'd0, "rst_count");
    check_pulses(0);

    // basic stream with consumer always ready
    ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(0, burst[i], 1'b0, 1'b0, 1'b1, 1'b0);
    expect_v(0, 8, 32'd4, "words_consumed");
    expect_v(0, 2, 32'd0, "count_after_stream");
    check_pulses(0);
    ready[0] = 1'b0;

    // even parity: good frame then bad parity bit
    req_aux = 32'(^8'h07);
    expect_v(1, 9, 32'd1, "even_parity_bit_of_07");
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_v(1, 2, 32'd1, "parity_count");
    expect_v(1, 0, 32'h07, "parity_head");
    expect_v(1, 4, 32'd1, "parity_pulse_lit");
    check_pulses(1);
    drain(1);

    // low stop bit then a good frame
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_v(0, 5, 32'd1, "frame_pulse_lit");
    expect_v(0, 2, 32'd1, "frame_count");
    expect_v(0, 0, 32'h3C, "frame_head");
    check_pulses(0);
    drain(0);

    // short glitch shorter than half a bit
    rx[0] = 1'b0;
    cyc(40);
    rx[0] = 1'b1;
    expect_v(0, 3, 32'd1, "glitch_busy_start");
    cyc(150);
    expect_v(0, 3, 32'd0, "glitch_back_idle");
    expect_v(0, 2, 32'd0, "glitch_count");
    check_pulses(0);

    // break: line held low well past one frame
    rx[0] = 1'b0;
    exp_ferr[0]++;
    cyc(12 * BP);
    expect_v(0, 3, 32'd0, "break_idle");
    rx[0] = 1'b1;
    cyc(20);
    expect_v(0, 5, 32'd2, "break_frame_pulse_lit");
    expect_v(0, 2, 32'd0, "break_count");
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_v(0, 0, 32'h5A, "after_break_head");
    check_pulses(0);
    drain(0);

    // fill past depth with no consumer
    for (int i = 1; i <= 9; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    expect_v(0, 2, 32'd8, "full_count");
    expect_v(0, 6, 32'd1, "overflow_pulse_lit");
    expect_v(0, 0, 32'h01, "full_head");
    check_pulses(0);
    drain(0);

    // full FIFO with a pop in the cycle of the ninth write
    for (int i = 1; i <= 8; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    saw = 1'b0;
    done = 1'b0;
    n = 0;
    fork
      send_frame(0, 8'h09, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        while (!done && n < 3000) begin
          if (busy[0]) begin
            saw = 1'b1;
          end else if (saw) begin
            ready[0] = 1'b1;
            cyc(1);
            ready[0] = 1'b0;
            done = 1'b1;
          end
          if (!done) begin
            cyc(1);
            n++;
          end
        end
      end
    join
    req_aux = 32'(!done);
    expect_v(0, 9, 32'd0, "busy_fall_timeout");
    expect_v(0, 2, 32'd8, "pop_write_count");
    expect_v(0, 0, 32'h02, "pop_write_head");
    expect_v(0, 6, 32'd1, "no_new_overflow");
    check_pulses(0);
    drain(0);

    // reset during data bit 4 with a word already buffered
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 1'b0);
    rx[0] = 1'b1;
    cyc(80);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    expect_v(0, 2, 32'd0, "midreset_count");
    expect_v(0, 1, 32'd0, "midreset_valid");
    expect_v(0, 0, 32'h00, "midreset_data");
    expect_v(0, 3, 32'd0, "midreset_busy");
    cyc(4 * BP);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_v(0, 2, 32'd1, "after_reset_count");
    expect_v(0, 0, 32'h81, "after_reset_head");
    check_pulses(0);
    check_pulses(1);
    drain(0);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
